// File: rtl/fe_fetch_if.sv
// Fetch-controller bundle: back-end redirect, I$ request/response ports and
// the decode-side head-of-buffer port.
interface fe_fetch_if;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ic_req_valid;
  logic [63:0] ic_req_pc;
  logic        ic_req_ready;
  logic        ic_rsp_valid;
  logic [63:0] ic_rsp_pc;
  logic [31:0] ic_rsp_inst;
  logic        ic_rsp_fault;
  logic        ic_rsp_ready;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;
  logic        out_ready;

  modport slave (
    input  redirect_valid, redirect_pc, ic_req_ready,
    input  ic_rsp_valid, ic_rsp_pc, ic_rsp_inst, ic_rsp_fault, out_ready,
    output ic_req_valid, ic_req_pc, ic_rsp_ready,
    output out_valid, out_pc, out_inst, out_fault
  );

  modport master (
    output redirect_valid, redirect_pc, ic_req_ready,
    output ic_rsp_valid, ic_rsp_pc, ic_rsp_inst, ic_rsp_fault, out_ready,
    input  ic_req_valid, ic_req_pc, ic_rsp_ready,
    input  out_valid, out_pc, out_inst, out_fault
  );
endinterface

// File: rtl/fe_fetch_ctrl.sv
// Front-end fetch controller: credit-limited I$ request issue, stale-response
// dropping after redirects, and a small registered instruction buffer.
//   state    | meaning
//   ST_RUN   | fetch requests may issue
//   ST_FAULT | a fetch fault was buffered; issue halts until redirect
module fe_fetch_ctrl #(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_0000_0000,
  parameter int          BUF_DEPTH = 4,
  parameter int          MAX_OUT   = 2
) (
  input logic        clk,
  input logic        rst_n,
  fe_fetch_if.slave  bus
);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  typedef enum logic {ST_RUN, ST_FAULT} state_t;

  state_t          state_q, state_d;
  logic [63:0]     pc_q;
  logic [CW-1:0]   cnt_q, outst_q, drop_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [63:0]     buf_pc_q    [BUF_DEPTH];
  logic [31:0]     buf_inst_q  [BUF_DEPTH];
  logic            buf_fault_q [BUF_DEPTH];

  logic [CW:0]     occ;
  logic            redir, req_valid, req_fire, rsp_fire, rsp_live, stale;
  logic            push, pop, out_valid;

  assign redir    = bus.redirect_valid;
  assign occ      = {1'b0, cnt_q} + {1'b0, outst_q};
  // Credits count both buffered and in-flight entries so a response always fits.
  assign req_valid = rst_n && (state_q == ST_RUN) && !redir &&
                     (outst_q < CW'(MAX_OUT)) && (occ < (CW+1)'(BUF_DEPTH));
  assign req_fire  = req_valid && bus.ic_req_ready;
  assign rsp_fire  = bus.ic_rsp_valid;
  assign rsp_live  = rsp_fire && (outst_q != '0);
  assign stale     = (drop_q != '0);
  assign push      = rsp_fire && !stale && !redir;
  assign out_valid = (cnt_q != '0) && !redir;
  assign pop       = out_valid && bus.out_ready;

  assign bus.ic_req_valid = req_valid;
  assign bus.ic_req_pc    = pc_q;
  assign bus.ic_rsp_ready = 1'b1;
  assign bus.out_valid    = out_valid;
  assign bus.out_pc       = buf_pc_q[rd_ptr_q];
  assign bus.out_inst     = buf_inst_q[rd_ptr_q];
  assign bus.out_fault    = buf_fault_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redir)                          state_d = ST_RUN;
    else if (push && bus.ic_rsp_fault)  state_d = ST_FAULT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      outst_q  <= '0;
      drop_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc_q[i]    <= '0;
        buf_inst_q[i]  <= '0;
        buf_fault_q[i] <= 1'b0;
      end
    end else if (redir) begin
      // Everything still in flight becomes stale; the response landing now is dropped.
      pc_q     <= bus.redirect_pc;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      outst_q  <= rsp_live ? outst_q - CW'(1) : outst_q;
      drop_q   <= rsp_live ? outst_q - CW'(1) : outst_q;
    end else begin
      if (req_fire) pc_q <= pc_q + 64'd4;
      if (req_fire && !rsp_live)      outst_q <= outst_q + CW'(1);
      else if (!req_fire && rsp_live) outst_q <= outst_q - CW'(1);
      if (rsp_fire && stale) drop_q <= drop_q - CW'(1);
      if (push) begin
        buf_pc_q[wr_ptr_q]    <= bus.ic_rsp_pc;
        buf_inst_q[wr_ptr_q]  <= bus.ic_rsp_inst;
        buf_fault_q[wr_ptr_q] <= bus.ic_rsp_fault;
        wr_ptr_q              <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (!push && pop) cnt_q <= cnt_q - CW'(1);
    end
  end
endmodule

// File: tb/tb_fe_fetch_ctrl.sv
// Directed bench for fe_fetch_ctrl: per-cycle vectors with hand-computed
// request/decode-port expectations, using a manually driven I$ responder.
module tb_fe_fetch_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fe_fetch_if bus ();

  fe_fetch_ctrl #(
    .RESET_PC  (64'h0000_0000_0000_1000),
    .BUF_DEPTH (4),
    .MAX_OUT   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        redir;
    logic [63:0] redir_pc;
    logic        req_rdy;
    logic        rsp_v;
    logic [63:0] rsp_pc;
    logic        rsp_f;
    logic        out_rdy;
    logic        e_req_v;
    logic [63:0] e_req_pc;
    logic        e_out_v;
    logic [63:0] e_out_pc;
    logic        e_out_f;
  } vec_t;

  localparam logic [63:0] HI8 = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam logic [63:0] HIC = 64'hFFFF_FFFF_FFFF_FFFC;

  function automatic logic [31:0] inst_of(logic [63:0] pc);
    return pc[31:0] ^ 32'h5A5A_0013;
  endfunction

  function automatic vec_t mk(logic redir, logic [63:0] rpc, logic req_rdy,
                              logic rsp_v, logic [63:0] rsp_pc, logic rsp_f,
                              logic out_rdy, logic erv, logic [63:0] erpc,
                              logic eov, logic [63:0] eopc, logic eof);
    vec_t v;
    v.redir = redir;  v.redir_pc = rpc;  v.req_rdy = req_rdy;
    v.rsp_v = rsp_v;  v.rsp_pc = rsp_pc; v.rsp_f = rsp_f;
    v.out_rdy = out_rdy;
    v.e_req_v = erv;  v.e_req_pc = erpc;
    v.e_out_v = eov;  v.e_out_pc = eopc; v.e_out_f = eof;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.ic_req_ready   = 1'b0;
    bus.ic_rsp_valid   = 1'b0;
    bus.ic_rsp_pc      = '0;
    bus.ic_rsp_inst    = '0;
    bus.ic_rsp_fault   = 1'b0;
    bus.out_ready      = 1'b0;
  endtask

  task automatic apply(vec_t v, string tag);
    @(negedge clk);
    bus.redirect_valid = v.redir;
    bus.redirect_pc    = v.redir_pc;
    bus.ic_req_ready   = v.req_rdy;
    bus.ic_rsp_valid   = v.rsp_v;
    bus.ic_rsp_pc      = v.rsp_pc;
    bus.ic_rsp_inst    = inst_of(v.rsp_pc);
    bus.ic_rsp_fault   = v.rsp_f;
    bus.out_ready      = v.out_rdy;
    #1;
    chk({tag, " req_valid"}, 64'(bus.ic_req_valid), 64'(v.e_req_v));
    if (v.e_req_v) chk({tag, " req_pc"}, bus.ic_req_pc, v.e_req_pc);
    chk({tag, " out_valid"}, 64'(bus.out_valid), 64'(v.e_out_v));
    if (v.e_out_v) begin
      chk({tag, " out_pc"}, bus.out_pc, v.e_out_pc);
      chk({tag, " out_inst"}, 64'(bus.out_inst), 64'(inst_of(v.e_out_pc)));
      chk({tag, " out_fault"}, 64'(bus.out_fault), 64'(v.e_out_f));
    end
    chk({tag, " rsp_ready"}, 64'(bus.ic_rsp_ready), 64'd1);
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    idle();
    bus.ic_req_ready = 1'b1;
    bus.out_ready    = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk({tag, " rst req_valid"}, 64'(bus.ic_req_valid), 64'd0);
    chk({tag, " rst out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, " rst out_pc"}, bus.out_pc, 64'd0);
    chk({tag, " rst out_inst"}, 64'(bus.out_inst), 64'd0);
    chk({tag, " rst out_fault"}, 64'(bus.out_fault), 64'd0);
    chk({tag, " rst rsp_ready"}, 64'(bus.ic_rsp_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
  endtask

  vec_t tbl [19];

  initial begin
    // redir rpc req_rdy | rsp_v rsp_pc f | out_rdy || req_v req_pc | out_v out_pc f
    tbl[0]  = mk(0, 0,       1, 0, 0,       0, 1, 1, 'h1000, 0, 0,       0);
    tbl[1]  = mk(0, 0,       1, 1, 'h1000,  0, 1, 1, 'h1004, 0, 0,       0);
    tbl[2]  = mk(0, 0,       1, 1, 'h1004,  0, 1, 1, 'h1008, 1, 'h1000,  0);
    tbl[3]  = mk(0, 0,       1, 1, 'h1008,  0, 1, 1, 'h100C, 1, 'h1004,  0);
    tbl[4]  = mk(0, 0,       1, 1, 'h100C,  0, 0, 1, 'h1010, 1, 'h1008,  0);
    tbl[5]  = mk(0, 0,       1, 1, 'h1010,  0, 0, 1, 'h1014, 1, 'h1008,  0);
    tbl[6]  = mk(0, 0,       1, 1, 'h1014,  0, 0, 0, 0,      1, 'h1008,  0);
    tbl[7]  = mk(0, 0,       1, 0, 0,       0, 0, 0, 0,      1, 'h1008,  0);
    tbl[8]  = mk(0, 0,       0, 0, 0,       0, 1, 0, 0,      1, 'h1008,  0);
    tbl[9]  = mk(0, 0,       0, 0, 0,       0, 1, 1, 'h1018, 1, 'h100C,  0);
    tbl[10] = mk(0, 0,       1, 0, 0,       0, 1, 1, 'h1018, 1, 'h1010,  0);
    tbl[11] = mk(0, 0,       1, 0, 0,       0, 0, 1, 'h101C, 1, 'h1014,  0);
    tbl[12] = mk(1, 'h2000,  1, 0, 0,       0, 1, 0, 0,      0, 0,       0);
    tbl[13] = mk(0, 0,       1, 1, 'h1018,  0, 1, 0, 0,      0, 0,       0);
    tbl[14] = mk(0, 0,       1, 1, 'h101C,  0, 1, 1, 'h2000, 0, 0,       0);
    tbl[15] = mk(0, 0,       1, 1, 'h2000,  0, 1, 1, 'h2004, 0, 0,       0);
    tbl[16] = mk(0, 0,       0, 1, 'h2004,  0, 1, 1, 'h2008, 1, 'h2000,  0);
    tbl[17] = mk(0, 0,       0, 0, 0,       0, 1, 1, 'h2008, 1, 'h2004,  0);
    tbl[18] = mk(0, 0,       0, 0, 0,       0, 1, 1, 'h2008, 0, 0,       0);

    idle();
    do_reset("init");
    for (int i = 0; i < 19; i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // Mid-operation reset, then fault stop and redirect restart.
    do_reset("mid");
    apply(mk(0, 0,      1, 0, 0,      0, 1, 1, 'h1000, 0, 0,      0), "flt0");
    apply(mk(0, 0,      1, 1, 'h1000, 0, 1, 1, 'h1004, 0, 0,      0), "flt1");
    apply(mk(0, 0,      1, 1, 'h1004, 0, 1, 1, 'h1008, 1, 'h1000, 0), "flt2");
    apply(mk(0, 0,      1, 1, 'h1008, 1, 1, 1, 'h100C, 1, 'h1004, 0), "flt3");
    apply(mk(0, 0,      1, 0, 0,      0, 1, 0, 0,      1, 'h1008, 1), "flt4");
    apply(mk(0, 0,      1, 0, 0,      0, 1, 0, 0,      0, 0,      0), "flt5");
    apply(mk(1, 'h3000, 1, 0, 0,      0, 1, 0, 0,      0, 0,      0), "flt6");
    apply(mk(0, 0,      1, 1, 'h100C, 0, 1, 1, 'h3000, 0, 0,      0), "flt7");
    apply(mk(0, 0,      1, 1, 'h3000, 0, 1, 1, 'h3004, 0, 0,      0), "flt8");
    apply(mk(0, 0,      0, 0, 0,      0, 1, 1, 'h3008, 1, 'h3000, 0), "flt9");

    // Held redirect (last PC wins) into the top of the address space.
    apply(mk(1, 'h5000, 1, 1, 'h3004, 0, 1, 0, 0,   0, 0,   0), "wrp0");
    apply(mk(1, HI8,    1, 0, 0,      0, 1, 0, 0,   0, 0,   0), "wrp1");
    apply(mk(0, 0,      1, 0, 0,      0, 1, 1, HI8, 0, 0,   0), "wrp2");
    apply(mk(0, 0,      1, 1, HI8,    0, 1, 1, HIC, 0, 0,   0), "wrp3");
    apply(mk(0, 0,      1, 1, HIC,    0, 1, 1, 0,   1, HI8, 0), "wrp4");
    apply(mk(0, 0,      1, 1, 0,      0, 1, 1, 4,   1, HIC, 0), "wrp5");
    apply(mk(0, 0,      0, 1, 4,      0, 1, 1, 8,   1, 0,   0), "wrp6");

    // Redirect coincident with a response and a decode pop.
    apply(mk(0, 0,      1, 0, 0,      0, 0, 1, 8,      1, 4,      0), "co0");
    apply(mk(1, 'h6000, 1, 1, 8,      0, 1, 0, 0,      0, 0,      0), "co1");
    apply(mk(0, 0,      1, 0, 0,      0, 1, 1, 'h6000, 0, 0,      0), "co2");
    apply(mk(0, 0,      0, 1, 'h6000, 0, 1, 1, 'h6004, 0, 0,      0), "co3");
    apply(mk(0, 0,      0, 0, 0,      0, 1, 1, 'h6004, 1, 'h6000, 0), "co4");
    apply(mk(0, 0,      0, 0, 0,      0, 1, 1, 'h6004, 0, 0,      0), "co5");

    @(negedge clk);
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
